// File: rtl/scoreboard_pkg.sv
// Shared constants and helpers for the register scoreboard.
// Optional bypass of same-cycle clears to the query ports: SCOREBOARD_BYPASS_EN.
package scoreboard_pkg;

    localparam int NUM_REGS_DEF = 32;
    localparam int NUM_CLR_DEF  = 2;

    function automatic int addr_w(input int n);
        return $clog2(n);
    endfunction

endpackage

// File: rtl/onehot_decoder.sv
// Enable-gated binary to one-hot decoder; a disabled decoder yields all-zero.
module onehot_decoder
    import scoreboard_pkg::*;
#(
    parameter int N  = NUM_REGS_DEF,
    parameter int AW = addr_w(N)
) (
    input  logic [AW-1:0] addr,
    input  logic          en,
    output logic [N-1:0]  onehot
);

    always_comb begin
        onehot = '0;
        if (en) onehot[addr] = 1'b1;
    end

endmodule

// File: rtl/reg_scoreboard.sv
// Register busy-bit scoreboard: one set port, NUM_CLR clear ports, two queries.
// Define SCOREBOARD_BYPASS_EN to hide same-cycle clears from busy_a/busy_b.
module reg_scoreboard
    import scoreboard_pkg::*;
#(
    parameter  int NUM_REGS = NUM_REGS_DEF,
    parameter  int NUM_CLR  = NUM_CLR_DEF,
    localparam int ADDR_W   = addr_w(NUM_REGS)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      flush,
    input  logic                      set_en,
    input  logic [ADDR_W-1:0]         set_addr,
    input  logic [NUM_CLR-1:0]        clr_en,
    input  logic [NUM_CLR*ADDR_W-1:0] clr_addr,
    input  logic [ADDR_W-1:0]         rd_addr_a,
    input  logic [ADDR_W-1:0]         rd_addr_b,
    output logic                      busy_a,
    output logic                      busy_b,
    output logic [NUM_REGS-1:0]       busy_vec,
    output logic [ADDR_W:0]           busy_cnt
);

    logic [NUM_REGS-1:0] r_busy;
    logic [ADDR_W:0]     r_cnt;
    logic [NUM_REGS-1:0] w_set_dec;
    logic [NUM_REGS-1:0] w_clr_dec [NUM_CLR];
    logic [NUM_REGS-1:0] w_clr_mask;
    logic [NUM_REGS-1:0] w_next;
    logic [ADDR_W:0]     w_cnt_next;
    logic                w_hit_a;
    logic                w_hit_b;

    onehot_decoder #(.N(NUM_REGS), .AW(ADDR_W)) u_set_dec (
        .addr   (set_addr),
        .en     (set_en),
        .onehot (w_set_dec)
    );

    for (genvar k = 0; k < NUM_CLR; k++) begin : g_clr
        onehot_decoder #(.N(NUM_REGS), .AW(ADDR_W)) u_clr_dec (
            .addr   (clr_addr[k*ADDR_W +: ADDR_W]),
            .en     (clr_en[k]),
            .onehot (w_clr_dec[k])
        );
    end

    always_comb begin
        w_clr_mask = '0;
        for (int k = 0; k < NUM_CLR; k++) begin
            w_clr_mask = w_clr_mask | w_clr_dec[k];
        end
    end

    // Set wins over clear; register 0 is hardwired free.
    always_comb begin
        w_next = (r_busy & ~w_clr_mask) | w_set_dec;
        if (flush) w_next = '0;
        w_next[0] = 1'b0;
    end

    always_comb begin
        w_cnt_next = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            w_cnt_next = w_cnt_next + (ADDR_W+1)'(w_next[i]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy <= '0;
            r_cnt  <= '0;
        end else begin
            r_busy <= w_next;
            r_cnt  <= w_cnt_next;
        end
    end

`ifdef SCOREBOARD_BYPASS_EN
    always_comb begin
        w_hit_a = 1'b0;
        w_hit_b = 1'b0;
        for (int k = 0; k < NUM_CLR; k++) begin
            if (clr_en[k] && clr_addr[k*ADDR_W +: ADDR_W] == rd_addr_a)
                w_hit_a = 1'b1;
            if (clr_en[k] && clr_addr[k*ADDR_W +: ADDR_W] == rd_addr_b)
                w_hit_b = 1'b1;
        end
    end
`else
    assign w_hit_a = 1'b0;
    assign w_hit_b = 1'b0;
`endif

    assign busy_a   = r_busy[rd_addr_a] & ~w_hit_a;
    assign busy_b   = r_busy[rd_addr_b] & ~w_hit_b;
    assign busy_vec = r_busy;
    assign busy_cnt = r_cnt;

endmodule
